// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, FSM state type and grant encoding helper for the 4-way arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Converts a requester index into its one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of requester lines, requester data and the arbitrated mux outputs.
// Latency: n/a (wiring only).
// Backpressure: none; requesters simply hold req until they see their grant.
interface mux_arb_if #(
  parameter int DW = 4
);
  logic [3:0]    req;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [DW-1:0] C;
  logic [DW-1:0] D;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] y_out;
  logic          y_valid;

  // Requester side: drives requests and data, observes the grant.
  modport master (
    output req, A, B, C, D,
    input  gnt, sel, y_out, y_valid
  );

  // Arbiter side.
  modport slave (
    input  req, A, B, C, D,
    output gnt, sel, y_out, y_valid
  );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or after start, wrapping 3->0.
// Latency: 0 cycles (pure logic).
// Backpressure: none.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester to start wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = start + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 data mux; ARB_HOLD_EN enables bursts of up to MAX_HOLD cycles.
// Latency: 1 cycle from req/data to gnt/sel/y_out/y_valid (all registered).
// Backpressure: none; a released grant re-arbitrates on the same edge with no idle bubble.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW       = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic      clk,
  input  logic      rst,
  mux_arb_if.slave  bus
);

  // Illegal hold lengths elaborate into this marker block; the arbiter assumes MAX_HOLD >= 1.
  if (MAX_HOLD < 1) begin : g_max_hold_invalid
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [DW-1:0]    y_q, y_d;
  logic [DW-1:0]    data [N_REQ];
  logic             found;
  logic [SEL_W-1:0] idx;
  logic             keep;

`ifdef ARB_HOLD_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign data[0] = bus.A;
  assign data[1] = bus.B;
  assign data[2] = bus.C;
  assign data[3] = bus.D;

  // Search always begins one past the most recent winner.
  rr_pick u_pick (
    .req   (bus.req),
    .start (last_q + SEL_W'(1)),
    .found (found),
    .idx   (idx)
  );

  // Next-state: hold the current grant if allowed, otherwise regrant from the search or go idle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    y_d     = y_q;
    keep    = 1'b0;
`ifdef ARB_HOLD_EN
    cnt_d   = cnt_q;
    keep    = (state_q == GRANT) && bus.req[sel_q] && (cnt_q < CNT_W'(MAX_HOLD));
`endif
    if (keep) begin
      y_d   = data[sel_q];
`ifdef ARB_HOLD_EN
      cnt_d = cnt_q + CNT_W'(1);
`endif
    end else if (found) begin
      state_d = GRANT;
      gnt_d   = onehot(idx);
      sel_d   = idx;
      last_d  = idx;
      y_d     = data[idx];
`ifdef ARB_HOLD_EN
      cnt_d   = CNT_W'(1);
`endif
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
`ifdef ARB_HOLD_EN
      cnt_d   = '0;
`endif
    end
  end

  // State and output registers; reset overrides any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      y_q     <= '0;
`ifdef ARB_HOLD_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      y_q     <= y_d;
`ifdef ARB_HOLD_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.y_out   = y_q;
  assign bus.y_valid = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized and directed checks of mux4_rr_arbiter against a rule-level reference model.
// Latency: model expects outputs one edge after inputs.
// Backpressure: n/a.
module tb_mux4_rr_arbiter;

  localparam int DW       = 4;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;

  mux_arb_if #(.DW(DW)) bus ();

  mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  // Reference state: who owns the mux (-1 = nobody), last winner, burst length, held outputs.
  int           m_owner;
  int           m_last;
  int           m_cnt;
  int           m_sel;
  logic [DW-1:0] m_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the arbitration rules, then compare.
  task automatic step(input logic r, input logic [3:0] rq);
    logic [DW-1:0] d [4];
    bit   hold;
    int   win;
    rst     = r;
    bus.req = rq;
    d[0] = bus.A; d[1] = bus.B; d[2] = bus.C; d[3] = bus.D;
    if (r) begin
      m_owner = -1; m_last = 3; m_cnt = 0; m_sel = 0; m_y = '0;
    end else begin
      hold = 1'b0;
`ifdef ARB_HOLD_EN
      hold = (m_owner >= 0) && rq[m_owner] && (m_cnt < MAX_HOLD);
`endif
      if (hold) begin
        m_y   = d[m_owner];
        m_cnt = m_cnt + 1;
      end else begin
        win = -1;
        for (int k = 1; k <= 4; k++) begin
          if (win < 0 && rq[(m_last + k) % 4]) win = (m_last + k) % 4;
        end
        if (win >= 0) begin
          m_owner = win; m_last = win; m_sel = win; m_y = d[win]; m_cnt = 1;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("gnt",     32'(bus.gnt),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("sel",     32'(bus.sel),     32'(m_sel));
    chk("y_out",   32'(bus.y_out),   32'(m_y));
    chk("y_valid", 32'(bus.y_valid), (m_owner < 0) ? 32'd0 : 32'd1);
  endtask

  task automatic set_data(input logic [DW-1:0] a, b, c, dd);
    bus.A = a; bus.B = b; bus.C = c; bus.D = dd;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    m_owner = -1; m_last = 3; m_cnt = 0; m_sel = 0; m_y = '0;
    rst = 1'b1;
    bus.req = '0;
    set_data(4'd1, 4'd2, 4'd3, 4'd4);
    #1;

    // Reset held with every request asserted: outputs stay zero.
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_y",   32'(bus.y_out), 32'd0);

    // Single requester C for three cycles, then idle.
    step(1'b0, 4'b0100);
    chk("t2_gnt", 32'(bus.gnt), 32'b0100);
    chk("t2_y",   32'(bus.y_out), 32'd3);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    chk("t2_idle", 32'(bus.y_valid), 32'd0);
    chk("t2_sel_kept", 32'(bus.sel), 32'd2);

    // B and D requesting after reset: B first, then D with no bubble when B drops.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1010);
    chk("t4_sel", 32'(bus.sel), 32'd1);
    step(1'b0, 4'b1000);
    chk("t4_gnt", 32'(bus.gnt), 32'b1000);
    chk("t4_y",   32'(bus.y_out), 32'd4);
    step(1'b0, 4'b0000);

    // Reset during a grant to C, then everyone requests: A wins first.
    step(1'b0, 4'b0100);
    step(1'b1, 4'b0100);
    chk("t5_valid", 32'(bus.y_valid), 32'd0);
    step(1'b0, 4'b1111);
    chk("t5_sel", 32'(bus.sel), 32'd0);

`ifdef ARB_HOLD_EN
    // All requesting: each requester owns the mux for MAX_HOLD cycles in turn.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 4 * MAX_HOLD + 1; i++) begin
      step(1'b0, 4'b1111);
      chk("t3_rot", 32'(bus.sel), 32'((i / MAX_HOLD) % 4));
    end
`else
    // All requesting: grant rotates every cycle, live data change on B shows up.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111);
      chk("t6_sel", 32'(bus.sel), 32'(i % 4));
      chk("t6_y",   32'(bus.y_out), 32'((i % 4) + 1));
    end
    bus.B = 4'd9;
    step(1'b0, 4'b1111);
    chk("t6_b9", 32'(bus.y_out), 32'd9);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      set_data(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      step(($urandom_range(0, 39) == 0), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
